// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t corr_c_o
);

  always_comb begin
    corr_c_o = digit_i;
    if (digit_i >= BCD_ADD3_THRESH) begin
      corr_c_o = digit_i + bcd_digit_t'(3);
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Define BCD_SATURATE_EN to clamp out-of-range results to 9999 instead of value mod 10000.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        ones_o,
  output logic [3:0]        tens_o,
  output logic [3:0]        hundreds_o,
  output logic [3:0]        thousands_o,
  output logic              over_o
);

  localparam int unsigned INT_DIGITS = 5;
  localparam int unsigned SCR_W      = INT_DIGITS * BCD_DIGIT_W;
  localparam int unsigned OUT_W      = DIGITS * BCD_DIGIT_W;
  localparam int unsigned CNT_W      = $clog2(DATA_W + 1);
  localparam int unsigned CAT_W      = SCR_W + DATA_W;

  bcd_state_t        state_q, state_d;
  logic [SCR_W-1:0]  scr_q, scr_d, scr_add;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  disp_q, disp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              over_q, over_d;
  logic [CAT_W-1:0]  shifted;

  // Parallel +3 correction on every scratch digit, applied before each shift.
  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i  (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corr_c_o (scr_add[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {scr_add, sh_q} << 1;

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    over_d  = over_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sh_d    = data_i;
          scr_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted[CAT_W-1 -: SCR_W];
        sh_d  = shifted[DATA_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Digits only update here so the display never shows a partial conversion.
        over_d = (scr_q[SCR_W-1 -: BCD_DIGIT_W] != '0);
        disp_d = scr_q[OUT_W-1:0];
`ifdef BCD_SATURATE_EN
        if (over_d) begin
          disp_d = {DIGITS{BCD_DIGIT_W'(9)}};
        end
`endif
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= IDLE;
      scr_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      over_q  <= over_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign over_o      = over_q;
  assign ones_o      = disp_q[0*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign tens_o      = disp_q[1*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign hundreds_o  = disp_q[2*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign thousands_o = disp_q[3*BCD_DIGIT_W +: BCD_DIGIT_W];

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter; honours BCD_SATURATE_EN for overflow expectations.
module tb_bcd_seq_converter;

  logic        clk_i;
  logic        reset;
  logic [15:0] data_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  ones_o;
  logic [3:0]  tens_o;
  logic [3:0]  hundreds_o;
  logic [3:0]  thousands_o;
  logic        over_o;
  logic [15:0] dig_obs;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BCD_SATURATE_EN
  localparam logic [15:0] EXP_10000 = 16'h9999;
  localparam logic [15:0] EXP_65535 = 16'h9999;
`else
  localparam logic [15:0] EXP_10000 = 16'h0000;
  localparam logic [15:0] EXP_65535 = 16'h5535;
`endif

  bcd_seq_converter #(.DATA_W(16), .DIGITS(4)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .data_i      (data_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ones_o      (ones_o),
    .tens_o      (tens_o),
    .hundreds_o  (hundreds_o),
    .thousands_o (thousands_o),
    .over_o      (over_o)
  );

  assign dig_obs = {thousands_o, hundreds_o, tens_o, ones_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Starts one conversion and waits (bounded) for done_o; caller sits #1 after a posedge.
  task automatic run_conv(input logic [15:0] val, output logic [15:0] dig, output logic ov,
                          output int lat, output int busy_n, output bit to);
    data_i  = val;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    busy_n  = busy_o ? 1 : 0;
    lat = 0; to = 1'b1; dig = '0; ov = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        lat = k; dig = dig_obs; ov = over_o; to = 1'b0;
        break;
      end
      if (busy_o) busy_n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; data_i = 16'd0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_checks++; if (over_o !== 1'b0) begin n_fail++; $display("FAIL reset_over: got %b want 0", over_o); end
    n_checks++; if (dig_obs !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", dig_obs); end
    reset = 1'b0;
    @(posedge clk_i); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_basic();
    logic [15:0] dig; logic ov; int lat, bn; bit to;
    run_conv(16'd1234, dig, ov, lat, bn, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL basic_latency: got %0d want 17", lat); end
    n_checks++; if (bn != 17) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 17", bn); end
    n_checks++; if (dig !== 16'h1234) begin n_fail++; $display("FAIL basic_digits: got %h want 1234", dig); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_over: got %b want 0", ov); end
  endtask

  task automatic test_boundaries();
    logic [15:0] vals [3] = '{16'd0, 16'd9999, 16'd10000};
    logic [15:0] exp_d [3] = '{16'h0000, 16'h9999, EXP_10000};
    logic        exp_o [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] dig; logic ov; int lat, bn; bit to;
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], dig, ov, lat, bn, to);
      n_checks++; if (lat != 17) begin n_fail++; $display("FAIL bound_latency[%0d]: got %0d want 17", vals[i], lat); end
      n_checks++; if (dig !== exp_d[i]) begin n_fail++; $display("FAIL bound_digits[%0d]: got %h want %h", vals[i], dig, exp_d[i]); end
      n_checks++; if (ov !== exp_o[i]) begin n_fail++; $display("FAIL bound_over[%0d]: got %b want %b", vals[i], ov, exp_o[i]); end
    end
  endtask

  task automatic test_max();
    logic [15:0] dig; logic ov; int lat, bn; bit to;
    run_conv(16'd65535, dig, ov, lat, bn, to);
    n_checks++; if (dig !== EXP_65535) begin n_fail++; $display("FAIL max_digits: got %h want %h", dig, EXP_65535); end
    n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL max_over: got %b want 1", ov); end
  endtask

  task automatic test_start_ignored();
    int done_n = 0; int lat = 0; logic [15:0] dig = '0;
    data_i = 16'd42; start_i = 1'b1;
    @(posedge clk_i); #1;
    for (int k = 1; k <= 40; k++) begin
      start_i = (k == 5 || k == 17);
      data_i  = start_i ? 16'd777 : 16'd42;
      @(posedge clk_i); #1;
      if (done_o) begin done_n++; lat = k; dig = dig_obs; end
    end
    start_i = 1'b0;
    n_checks++; if (done_n != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_n); end
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL ignore_latency: got %0d want 17", lat); end
    n_checks++; if (dig !== 16'h0042) begin n_fail++; $display("FAIL ignore_digits: got %h want 0042", dig); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got busy %b want 0", busy_o); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] dig; logic ov; int lat, bn; bit to; int done_n = 0; int busy_n = 0;
    run_conv(16'd5678, dig, ov, lat, bn, to);
    n_checks++; if (dig !== 16'h5678) begin n_fail++; $display("FAIL abort_pre_digits: got %h want 5678", dig); end
    data_i = 16'd1111; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_i); #1;
      if (done_o) done_n++;
    end
    reset = 1'b1;
    @(posedge clk_i); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    n_checks++; if (over_o !== 1'b0) begin n_fail++; $display("FAIL abort_over: got %b want 0", over_o); end
    n_checks++; if (dig_obs !== 16'h0000) begin n_fail++; $display("FAIL abort_digits: got %h want 0000", dig_obs); end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      if (done_o) done_n++;
      if (busy_o) busy_n++;
    end
    n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_n); end
    n_checks++; if (busy_n != 0) begin n_fail++; $display("FAIL abort_idle: got %0d busy cycles want 0", busy_n); end
    run_conv(16'd1111, dig, ov, lat, bn, to);
    n_checks++; if (dig !== 16'h1111) begin n_fail++; $display("FAIL abort_restart_digits: got %h want 1111", dig); end
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL abort_restart_latency: got %0d want 17", lat); end
  endtask

  task automatic test_data_change();
    int hold_bad = 0; int lat = 0; logic [15:0] dig = '0;
    data_i = 16'd3021; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      data_i = 16'($urandom);
      @(posedge clk_i); #1;
      if (done_o) begin lat = k; dig = dig_obs; break; end
      if (dig_obs !== 16'h1111) hold_bad++;
    end
    n_checks++; if (hold_bad != 0) begin n_fail++; $display("FAIL hold_digits: got %0d cycles changed want 0", hold_bad); end
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL change_latency: got %0d want 17", lat); end
    n_checks++; if (dig !== 16'h3021) begin n_fail++; $display("FAIL change_digits: got %h want 3021", dig); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_max();
    test_start_ignored();
    test_reset_abort();
    test_data_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential (shift-and-add-3) binary-to-BCD converter.
- Sits directly downstream of the ADC front end; consumes its 16-bit raw sample.
- Drives the four decimal digits into the digit multiplexer / seven-segment decoder path.
- Replaces single-cycle combinational conversion with a multi-cycle FSM. This keeps LUT count low on the MachXO2 at the 2.08 MHz system clock. Adds a start/done handshake and an overflow flag.

Parameters:
- DATA_W, 16, width of binary input; legal range 4..16.
- DIGITS, 4, number of BCD digits presented on outputs; fixed at 4.
- INT_DIGITS (localparam), 5, internal scratch digits; enough for 65535.

Ports:
- clk_i  in  1  system clock (2.08 MHz oscillator net)
- reset  in  1  synchronous, active-high reset
- data_i  in  DATA_W  unsigned binary sample from the ADC
- start_i  in  1  request conversion of data_i; sampled only in IDLE
- busy_o  out  1  high while a conversion is in progress (SHIFT or DONE)
- done_o  out  1  one-cycle pulse when new digits are valid
- ones_o  out  4  BCD 10^0 digit
- tens_o  out  4  BCD 10^1 digit
- hundreds_o  out  4  BCD 10^2 digit
- thousands_o  out  4  BCD 10^3 digit
- over_o  out  1  last converted value exceeded 9999

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-high, port name reset.
- Reset values:
  - State IDLE.
  - busy_o=0, done_o=0, over_o=0.
  - All digit outputs 4'd0.
  - Scratch registers and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start_i=1: latch data_i into shift register, clear 20-bit BCD scratch, load bit counter with DATA_W, go to SHIFT.
  - SHIFT, each cycle:
    - For every scratch digit >= 5, add 3 to that digit (all digits in parallel).
    - Then shift {scratch, shift_reg} left one bit.
    - Decrement the counter. On the cycle the counter reaches 0, go to DONE.
  - DONE (one cycle): register the output digits and over_o, assert done_o, go to IDLE.
- Latency: start accepted at edge N; digits and done_o are visible after edge N+DATA_W+1 (17 cycles for DATA_W=16). Back-to-back throughput is one conversion per DATA_W+2 cycles.
- Output digits hold their previous result for the whole conversion; they never show partial values. They change only on the DONE edge.
- over_o = (scratch digit 4 != 0). Updated only in DONE.
- Overflow digit mapping (ten-thousands digit non-zero): see Optional Feature.
- start_i while busy_o=1, including the DONE cycle, is ignored. No queuing. data_i changes during a conversion have no effect.
- Reset asserted mid-conversion aborts immediately. All outputs return to reset values and no done_o is issued.
- DATA_W < 16: data_i is zero-extended internally; the same FSM applies with counter load DATA_W.

Optional Feature:
- Macro BCD_SATURATE_EN.
- Defined: when over_o would be 1, the outputs are forced to 9,9,9,9 (thousands..ones).
- Undefined: the outputs show the low four decimal digits (value mod 10000); over_o is still set.
- In-range values (<= 9999) behave identically either way.

Decomposition:
- Shared package bcd_pkg:
  - enum bcd_state_t {IDLE, SHIFT, DONE}.
  - Constant BCD_DIGIT_W = 4.
  - Constant BCD_ADD3_THRESH = 4'd5.
  - typedef bcd_digit_t.
- One natural sub-module: bcd_add3. Combinational 4-bit digit correction (d>=5 ? d+3 : d), instantiated INT_DIGITS times.
- FSM, counter and output registers remain in bcd_seq_converter.

Test Plan:
- After reset, data_i=16'd1234 with a one-cycle start_i -> busy_o high for 17 cycles. done_o pulses at cycle 17. Digits 1,2,3,4; over_o=0.
- data_i=0, then 9999, then 10000, each started on the first IDLE cycle after the previous done_o. Required results:
  - 0 -> 0,0,0,0, over_o=0.
  - 9999 -> 9,9,9,9, over_o=0.
  - 10000 -> over_o=1, digits 9,9,9,9 with BCD_SATURATE_EN, else 0,0,0,0.
- data_i=16'd65535 -> over_o=1; digits 9,9,9,9 with macro, 5,5,3,5 without.
- Start with 16'd42. Pulse start_i with 16'd777 at cycles 5 and 17 (the DONE cycle) -> both ignored. Result 0,0,4,2; exactly one done_o.
- Complete a conversion of 16'd5678. Start 16'd1111, then assert reset at cycle 8 -> no done_o. All outputs 0 on the next edge; FSM in IDLE. A fresh start of 16'd1111 converts correctly.
- Change data_i every cycle during a conversion of 16'd3021 -> digits 3,0,2,1. Digits hold the previous result until the DONE edge.
